// File: rtl/pzbcm_fifo_push_arbiter.sv
// Packet-level round-robin arbiter for the push side of a shared FIFO; a grant is held until the last beat of a packet is accepted.
// Optional per-requester saturating push counters are enabled with `define PZBCM_FIFO_PUSH_ARBITER_COUNT_EN.
module pzbcm_fifo_push_arbiter #(
    parameter int  REQUESTERS  = 2,
    parameter int  WIDTH       = 8,
    parameter type TYPE        = logic [WIDTH-1:0],
    parameter int  COUNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REQUESTERS-1:0] i_valid,
    output logic [REQUESTERS-1:0] o_ready,
    input  logic [REQUESTERS-1:0] i_last,
    input  TYPE                   i_data [REQUESTERS],
    output logic                  o_push,
    output TYPE                   o_data,
    input  logic                  i_full,
    input  logic                  i_almost_full,
`ifdef PZBCM_FIFO_PUSH_ARBITER_COUNT_EN
    output logic [REQUESTERS-1:0][COUNT_WIDTH-1:0] o_push_count,
`endif
    output logic [REQUESTERS-1:0] o_grant
);
    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    ptr_t                  ptr_q, ptr_d;
    ptr_t                  owner;
    ptr_t                  next_ptr;
    logic [REQUESTERS-1:0] others;
    logic                  last_accept;

    // First requester at or after ptr, cyclically; lower k wins because it is assigned last.
    function automatic logic [REQUESTERS-1:0] rr_pick(input logic [REQUESTERS-1:0] req, input ptr_t ptr);
        logic [REQUESTERS-1:0] pick;
        pick = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (req[i] && (((int'(ptr) + k) % REQUESTERS) == i)) begin
                    pick    = '0;
                    pick[i] = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner  = '0;
        o_data = i_data[0];
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_q[i]) begin
                owner  = ptr_t'(i);
                o_data = i_data[i];
            end
        end
        next_ptr    = (int'(owner) == REQUESTERS - 1) ? '0 : owner + 1'b1;
        o_ready     = grant_q & {REQUESTERS{~i_full}};
        o_push      = |(i_valid & o_ready);
        last_accept = |(i_valid & o_ready & i_last);
        others      = i_valid & ~grant_q;
        o_grant     = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|i_valid && !i_almost_full) begin
                    grant_d = rr_pick(i_valid, ptr_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_accept) begin
                    ptr_d = next_ptr;
                    // Hand over in the same edge so back-to-back packets have no bubble.
                    if (|others && !i_almost_full) begin
                        grant_d = rr_pick(others, next_ptr);
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            assert (!(o_push && i_full));
            assert ($onehot0(grant_q));
        end
    end

`ifdef PZBCM_FIFO_PUSH_ARBITER_COUNT_EN
    logic [REQUESTERS-1:0][COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (i_valid[i] && o_ready[i] && (count_q[i] != '1)) begin
                count_d[i] = count_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_push_count = count_q;
`endif

endmodule

// File: tb/tb_pzbcm_fifo_push_arbiter.sv
// Directed bench for pzbcm_fifo_push_arbiter with a simple per-requester packet source model.
module tb_pzbcm_fifo_push_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] last;
    logic [7:0] data [2];
    logic       push;
    logic [7:0] odata;
    logic       full;
    logic       afull;
    logic [1:0] grant;
`ifdef PZBCM_FIFO_PUSH_ARBITER_COUNT_EN
    logic [1:0][1:0] pcount;
`endif

    pzbcm_fifo_push_arbiter #(
        .REQUESTERS  (2),
        .WIDTH       (8),
        .COUNT_WIDTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_last        (last),
        .i_data        (data),
        .o_push        (push),
        .o_data        (odata),
        .i_full        (full),
        .i_almost_full (afull),
`ifdef PZBCM_FIFO_PUSH_ARBITER_COUNT_EN
        .o_push_count  (pcount),
`endif
        .o_grant       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Source model state
    int         sent [2];
    int         nbeats [2];
    int         plen [2];
    logic [1:0] en;

    // Values sampled at the falling edge of the last cycle
    logic       s_push;
    logic [7:0] s_data;
    logic [1:0] s_grant;
    logic [1:0] s_ready;

    logic [7:0] b_data [12] = '{8'h00, 8'h01, 8'h02, 8'h40, 8'h41, 8'h42,
                                8'h03, 8'h04, 8'h05, 8'h43, 8'h44, 8'h45};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            valid[r] = en[r] && (sent[r] < nbeats[r]);
            data[r]  = 8'(r * 64 + sent[r]);
            last[r]  = ((sent[r] % plen[r]) == plen[r] - 1);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 2; r++) begin
            sent[r]   = 0;
            nbeats[r] = 0;
            plen[r]   = 1;
        end
        en = 2'b00;
        drive();
    endtask

    // One clock cycle: sample at negedge, advance sources after the rising edge.
    task automatic cyc();
        logic [1:0] acc;
        @(negedge clk);
        s_push  = push;
        s_data  = odata;
        s_grant = grant;
        s_ready = ready;
        acc     = valid & ready;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) if (acc[r]) sent[r]++;
        drive();
    endtask

    task automatic expect_cyc(input string tag, input logic exp_push, input logic [7:0] exp_data,
                              input logic [1:0] exp_grant);
        cyc();
        check_eq({tag, "_push"}, 32'(s_push), 32'(exp_push));
        if (exp_push) check_eq({tag, "_data"}, 32'(s_data), 32'(exp_data));
        check_eq({tag, "_grant"}, 32'(s_grant), 32'(exp_grant));
    endtask

    task automatic do_reset();
        model_clear();
        full  = 1'b0;
        afull = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        full  = 1'b0;
        afull = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        cyc();
        check_eq("rst_grant", 32'(s_grant), 0);
        check_eq("rst_ready", 32'(s_ready), 0);
        check_eq("rst_push", 32'(s_push), 0);

        // Single 4-beat packet on requester 0
        en = 2'b01; nbeats[0] = 4; plen[0] = 4; drive();
        expect_cyc("a0", 1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            expect_cyc("a_beat", 1'b1, 8'(i), 2'b01);
            check_eq("a_ready", 32'(s_ready), 32'(2'b01));
        end
        expect_cyc("a_idle", 1'b0, 8'h00, 2'b00);

        // Both requesters, two 3-beat packets each: alternate with no bubble
        do_reset();
        en = 2'b11; nbeats[0] = 6; plen[0] = 3; nbeats[1] = 6; plen[1] = 3; drive();
        expect_cyc("b0", 1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 12; i++) begin
            expect_cyc("b_beat", 1'b1, b_data[i], ((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
        end
        expect_cyc("b_idle", 1'b0, 8'h00, 2'b00);

        // FIFO full for 5 cycles mid-packet
        do_reset();
        en = 2'b01; nbeats[0] = 4; plen[0] = 4; drive();
        expect_cyc("c0", 1'b0, 8'h00, 2'b00);
        expect_cyc("c_b0", 1'b1, 8'h00, 2'b01);
        expect_cyc("c_b1", 1'b1, 8'h01, 2'b01);
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_cyc("c_full", 1'b0, 8'h00, 2'b01);
            check_eq("c_full_ready", 32'(s_ready), 0);
        end
        full = 1'b0;
        expect_cyc("c_b2", 1'b1, 8'h02, 2'b01);
        expect_cyc("c_b3", 1'b1, 8'h03, 2'b01);
        expect_cyc("c_idle", 1'b0, 8'h00, 2'b00);

        // Almost-full blocks a new grant but not a packet in progress
        do_reset();
        en = 2'b10; nbeats[1] = 2; plen[1] = 2; afull = 1'b1; drive();
        for (int i = 0; i < 3; i++) expect_cyc("d_af_idle", 1'b0, 8'h00, 2'b00);
        afull = 1'b0;
        expect_cyc("d_grant_edge", 1'b0, 8'h00, 2'b00);
        expect_cyc("d_b0", 1'b1, 8'h40, 2'b10);
        afull = 1'b1;
        expect_cyc("d_b1_af", 1'b1, 8'h41, 2'b10);
        expect_cyc("d_idle", 1'b0, 8'h00, 2'b00);
        afull = 1'b0;

        // Reset mid-packet clears the grant and returns the pointer to requester 0
        model_clear();
        en = 2'b11; nbeats[0] = 1; plen[0] = 1; nbeats[1] = 4; plen[1] = 4; drive();
        expect_cyc("e0", 1'b0, 8'h00, 2'b00);
        expect_cyc("e_r0", 1'b1, 8'h00, 2'b01);
        expect_cyc("e_r1b0", 1'b1, 8'h40, 2'b10);
        rst = 1'b1;
        expect_cyc("e_r1b1", 1'b1, 8'h41, 2'b10);
        rst = 1'b0;
        nbeats[0] = 2; drive();
        expect_cyc("e_after_rst", 1'b0, 8'h00, 2'b00);
        check_eq("e_after_rst_ready", 32'(s_ready), 0);
        expect_cyc("e_ptr0", 1'b1, 8'h01, 2'b01);

`ifdef PZBCM_FIFO_PUSH_ARBITER_COUNT_EN
        // Saturating counters with a 2-bit width
        do_reset();
        en = 2'b10; nbeats[1] = 5; plen[1] = 5; drive();
        for (int i = 0; i < 7; i++) cyc();
        check_eq("f_cnt1", 32'(pcount[1]), 3);
        check_eq("f_cnt0", 32'(pcount[0]), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
